// File: rtl/key_event_scheduler.sv
// key_event_scheduler: converts debounced key levels into discrete key events.
// Press edges and auto-repeat ticks set per-key pending flags, a round-robin
// arbiter grants one pending key per cycle into a show-ahead FIFO, and the
// consumer drains the FIFO through a valid/ready handshake.
module key_event_scheduler #(
  parameter int NKEYS         = 5,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_level,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [2:0]       ev_code,
  output logic             ev_repeat,
  output logic             overflow
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam logic [19:0]     DELAY_LAST  = 20'(REPEAT_DELAY - 1);
  localparam logic [19:0]     PERIOD_LAST = 20'(REPEAT_PERIOD - 1);
  localparam logic [2:0]      RR_INIT     = 3'(NKEYS - 1);
  localparam logic [AW:0]     DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE     = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE     = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // State registers and their next-state values
  logic [NKEYS-1:0] key_prev_q, key_prev_d;
  logic [NKEYS-1:0] pending_q, pending_d;
  logic [NKEYS-1:0] rep_q, rep_d;
  logic             overflow_q, overflow_d;
  rpt_state_e       state_q, state_d;
  logic [19:0]      cnt_q, cnt_d;
  logic [NKEYS-1:0] held_q, held_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [3:0]       mem_q [FIFO_DEPTH];

  // Combinational helpers
  logic [NKEYS-1:0] press_s;
  logic             tick_s;
  logic [NKEYS-1:0] tick_vec_s;
  logic             full_s;
  logic             grant_s;
  logic [2:0]       grant_idx_s;
  logic [NKEYS-1:0] grant_vec_s;
  logic             push_rep_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [3:0]       head_s;

  assign press_s    = key_level & ~key_prev_q;
  assign key_prev_d = key_level;
  assign tick_vec_s = tick_s ? held_q : '0;
  // Full is judged on the registered occupancy: a pop in the same cycle does not open a slot.
  assign full_s     = (count_q == DEPTH_C);
  assign push_s     = grant_s;
  assign pop_s      = (|count_q) & ev_ready;
  assign head_s     = mem_q[rd_ptr_q];

  assign ev_valid   = |count_q;
  assign ev_code    = ev_valid ? head_s[3:1] : 3'd0;
  assign ev_repeat  = ev_valid ? head_s[0] : 1'b0;
  assign overflow   = overflow_q;

  // Repeat FSM: tracks a single held key and emits delay/period ticks for it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    tick_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ($onehot(key_level)) begin
          held_d  = key_level;
          cnt_d   = 20'd0;
          state_d = ST_DELAY;
        end else begin
          cnt_d   = 20'd0;
        end
      end
      ST_DELAY: begin
        if (key_level != held_q) begin
          cnt_d   = 20'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == DELAY_LAST) begin
          tick_s  = 1'b1;
          cnt_d   = 20'd0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d   = cnt_q + 20'd1;
        end
      end
      ST_REPEAT: begin
        if (key_level != held_q) begin
          cnt_d   = 20'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == PERIOD_LAST) begin
          tick_s  = 1'b1;
          cnt_d   = 20'd0;
        end else begin
          cnt_d   = cnt_q + 20'd1;
        end
      end
      default: begin
        cnt_d   = 20'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Round-robin arbiter: first pending key after the last winner, only when a slot is free.
  always_comb begin : arb
    int idx;
    idx         = 0;
    grant_s     = 1'b0;
    grant_idx_s = rr_ptr_q;
    grant_vec_s = '0;
    push_rep_s  = 1'b0;
    if (!full_s) begin
      for (int k = 1; k <= NKEYS; k++) begin
        idx = int'(rr_ptr_q) + k;
        idx = (idx >= NKEYS) ? (idx - NKEYS) : idx;
        if (!grant_s && pending_q[idx]) begin
          grant_s          = 1'b1;
          grant_idx_s      = idx[2:0];
          grant_vec_s[idx] = 1'b1;
          push_rep_s       = rep_q[idx];
        end else begin
          grant_s          = grant_s;
        end
      end
    end else begin
      grant_s = 1'b0;
    end
    rr_ptr_d = grant_s ? grant_idx_s : rr_ptr_q;
  end

  // Pending/rep bookkeeping: a new set beats a same-cycle grant; a set on an ungranted pending key merges and flags overflow.
  always_comb begin
    pending_d = pending_q;
    rep_d     = rep_q;
    drop_s    = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (press_s[i] || tick_vec_s[i]) begin
        pending_d[i] = 1'b1;
        if (press_s[i]) begin
          rep_d[i] = 1'b0;
        end else if (pending_q[i] && !grant_vec_s[i]) begin
          rep_d[i] = rep_q[i];
        end else begin
          rep_d[i] = 1'b1;
        end
        if (pending_q[i] && !grant_vec_s[i]) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_s;
        end
      end else if (grant_vec_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
    overflow_d = overflow_q | drop_s;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State register update with synchronous reset; FIFO storage written on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev_q <= '0;
      pending_q  <= '0;
      rep_q      <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= 20'd0;
      held_q     <= '0;
      rr_ptr_q   <= RR_INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_q[j] <= 4'd0;
      end
    end else begin
      key_prev_q <= key_prev_d;
      pending_q  <= pending_d;
      rep_q      <= rep_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= {grant_idx_s, push_rep_s};
      end
    end
  end

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Turns the five debounced key levels from the key debouncer into a stream of discrete key events for the control logic. Detects presses, generates auto-repeat for a single held key, arbitrates round-robin among keys with pending events, and queues granted events in a small FIFO with a valid/ready output handshake. It sits directly between the debouncer outputs and any consumer of key commands.

## Interface
- NKEYS, 5, number of key inputs (2..8)
- REPEAT_DELAY, 500000, cycles a lone key must be held before its first repeat event (≥2)
- REPEAT_PERIOD, 100000, cycles between subsequent repeat events (≥2)
- FIFO_DEPTH, 4, event queue entries (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- key_level  in  NKEYS  debounced key levels, 1 = pressed
- ev_ready  in  1  consumer accepts head event this cycle
- ev_valid  out  1  FIFO non-empty; head event presented
- ev_code  out  3  key index of head event
- ev_repeat  out  1  head event is auto-repeat (0 = fresh press)
- overflow  out  1  sticky: an event was dropped

## Operation
- Edge detect: key_prev registered copy of key_level; press[i] = key_level[i] & ~key_prev[i]. Releases generate no event.
- Pending: per-key pending[i] and rep[i]. Set by press[i] (rep←0) or repeat tick for i (rep←rep if already pending, else 1). Granted key clears pending unless a set arrives same cycle (set wins).
- Drop: set arriving on a key already pending and not granted that cycle is merged (one event), and overflow←1. overflow clears only on rst.
- Arbiter: if any pending and FIFO not full (full evaluated at cycle start; a same-cycle pop does not free a slot), grant first pending key scanning rr_ptr+1, rr_ptr+2, … mod NKEYS; push {code, rep}; rr_ptr←granted index. Full FIFO: no grant, pending held. One grant per cycle max.
- Repeat FSM, 20-bit counter:
  - IDLE: key_level one-hot → capture held index, cnt←0, go DELAY.
  - DELAY: cnt++; at cnt==REPEAT_DELAY-1 emit tick, cnt←0, go REPEAT.
  - REPEAT: cnt++; at cnt==REPEAT_PERIOD-1 emit tick, cnt←0.
  - DELAY/REPEAT: key_level ≠ captured one-hot → IDLE that cycle, no tick. Two or more keys held → never repeat.
- FIFO: show-ahead; pop when ev_valid & ev_ready. ev_ready while empty ignored. Push and pop same cycle (not full) allowed; occupancy unchanged.

## Timing
- Reset values: ev_valid 0, ev_code 0, ev_repeat 0, overflow 0; key_prev 0, pending 0, rep 0, FIFO empty, FSM IDLE, cnt 0, rr_ptr NKEYS-1 (key 0 wins first).
- Key held across reset deassertion: key_prev=0, so a press is detected in the first cycle after reset.
- Latency, empty FIFO, no contention: key_level rises before edge N → pending set at N → grant/push at N+1 → ev_valid high after N+1.
- Repeat tick at edge T sets pending at T; event visible two edges later, as for a press.
- First repeat event REPEAT_DELAY cycles after FSM enters DELAY (one cycle after key_level rise); then every REPEAT_PERIOD cycles while the consumer keeps up.
- ev_code/ev_repeat stable while ev_valid & ~ev_ready.
- rst mid-operation: everything returns to reset values next edge; queued and pending events discarded.

## Test plan
- Reset, key_level=00001 one cycle before end of reset, ev_ready=1 → after reset exactly one event code 0, repeat 0, ev_valid high for 1 cycle; no further events while held and REPEAT_DELAY not elapsed.
- key_level 00000→10101 in one cycle, ev_ready=1 → events codes 0,2,4 on consecutive cycles, all repeat 0; no repeats (three keys held).
- REPEAT_DELAY=20, REPEAT_PERIOD=5, hold key 3 for 40 cycles, ev_ready=1 → press event, first repeat 20 cycles after hold start, then repeats every 5 cycles (4 total), all code 3, repeat 1; release → no more events.
- ev_ready=0, FIFO_DEPTH=4, press keys 0..4 one at a time → ev_valid stays on code 0, 4 entries queued, key 4 stays pending; ev_ready=1 → codes 0,1,2,3,4; overflow stays 0.
- ev_ready=0, FIFO full, key 1 pending, key 1 released and re-pressed → overflow=1 and stays 1; only one code-1 event delivered after draining.
- Hold key 2 in REPEAT state, assert rst one cycle mid-queue → ev_valid=0, overflow=0 next cycle; new code-2 press event follows (key_prev cleared).
